// File: rtl/cmp_rgb_led_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_rgb_led_if
//  Description : Operand/result handshake bundle for cmp_rgb_led. The master
//                side (sample logic) drives operand pairs; the slave side
//                (comparator) returns ready and the registered compare result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmp_rgb_led_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_in;
    logic             ready_out;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             result_valid;

    modport master (
        output a, b, valid_in,
        input  ready_out, gt, eq, lt, result_valid
    );

    modport slave (
        input  a, b, valid_in,
        output ready_out, gt, eq, lt, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/cmp_rgb_led.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_rgb_led
//  Description : Clocked magnitude comparator feeding an RGB LED. Operand
//                pairs arrive over a valid/ready handshake, the GT/EQ/LT
//                result is registered, debounced over STABLE_CNT identical
//                samples, and the displayed class drives one LED through a
//                shared PWM dimmer.
//  Options     : define CMP_RGB_SIGNED_EN for a two's-complement compare;
//                unsigned compare otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_rgb_led #(
    parameter int WIDTH      = 8,
    parameter int STABLE_CNT = 4,
    parameter int PWM_BITS   = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    cmp_rgb_led_if.slave             bus,
    input  wire logic [PWM_BITS-1:0] brightness,
    output logic                     red,
    output logic                     green,
    output logic                     blue
);

    // Match counter must be able to hold STABLE_CNT itself.
    localparam int CNT_W = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Colour class encoding shared by candidate, displayed and sampled class.
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_GT   = 2'd1;
    localparam logic [1:0] CLS_EQ   = 2'd2;
    localparam logic [1:0] CLS_LT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [1:0]           cls_q;
    logic [1:0]           cand;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           disp;
    logic [PWM_BITS-1:0]  pwm_cnt;

    logic [1:0]           cls_new;
    logic [1:0]           cand_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 pwm_on;

    // Classify the captured operand pair.
    always_comb begin
        cls_new = CLS_EQ;
`ifdef CMP_RGB_SIGNED_EN
        if ($signed(a_q) > $signed(b_q)) begin
            cls_new = CLS_GT;
        end else if ($signed(a_q) < $signed(b_q)) begin
            cls_new = CLS_LT;
        end
`else
        if (a_q > b_q) begin
            cls_new = CLS_GT;
        end else if (a_q < b_q) begin
            cls_new = CLS_LT;
        end
`endif
    end

    // Debounce step: extend the run on a repeat (saturating), else restart it.
    always_comb begin
        cand_next = cls_q;
        cnt_next  = CNT_ONE;
        if (cls_q == cand) begin
            cand_next = cand;
            cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end
    end

    // Handshake FSM: capture -> compare/publish -> debounce, then re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bus.ready_out    <= 1'b1;
            bus.gt           <= 1'b0;
            bus.eq           <= 1'b0;
            bus.lt           <= 1'b0;
            bus.result_valid <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            cls_q            <= CLS_NONE;
            cand             <= CLS_NONE;
            cnt              <= '0;
            disp             <= CLS_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.result_valid <= 1'b0;
                    if (bus.valid_in && bus.ready_out) begin
                        a_q           <= bus.a;
                        b_q           <= bus.b;
                        bus.ready_out <= 1'b0;
                        state         <= S_CMP;
                    end
                end
                S_CMP: begin
                    bus.gt           <= (cls_new == CLS_GT);
                    bus.eq           <= (cls_new == CLS_EQ);
                    bus.lt           <= (cls_new == CLS_LT);
                    bus.result_valid <= 1'b1;
                    cls_q            <= cls_new;
                    state            <= S_UPD;
                end
                S_UPD: begin
                    bus.result_valid <= 1'b0;
                    cand             <= cand_next;
                    cnt              <= cnt_next;
                    if (cnt_next == CNT_MAX) begin
                        disp <= cand_next;
                    end
                    bus.ready_out    <= 1'b1;
                    state            <= S_IDLE;
                end
                default: begin
                    bus.result_valid <= 1'b0;
                    bus.ready_out    <= 1'b1;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

    // All-ones brightness bypasses the compare so the LED is solidly lit.
    assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

    // Free-running PWM counter and registered LED pins (glitch-free outputs).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            red     <= 1'b0;
            green   <= 1'b0;
            blue    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            red     <= pwm_on && (disp == CLS_GT);
            green   <= pwm_on && (disp == CLS_EQ);
            blue    <= pwm_on && (disp == CLS_LT);
        end
    end

endmodule
`default_nettype wire
